// File: rtl/vga_scanout_pkg.sv
// Shared constants, FSM encoding and row helper for the VGA scanout block.
package vga_scanout_pkg;

    localparam int CELL_SIZE = 32;
    localparam int GRID_COLS = 32;
    localparam int GRID_ROWS = 16;

    localparam int H_FPORCH = 1025;
    localparam int H_NEXT   = 1439;
    localparam int V_NEXT   = 740;
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 512;

    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int COLOR_W = 6;
    localparam int DATA_W  = GRID_COLS;
    localparam int ROW_W   = $clog2(GRID_ROWS);
    localparam int COL_W   = $clog2(GRID_COLS);
    localparam int CELL_SH = $clog2(CELL_SIZE);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_e;

    // Framebuffer row that will be on screen during the line after y.
    function automatic logic [ROW_W-1:0] next_row(input logic [Y_W-1:0] y);
        logic [Y_W-1:0] ny;
        ny = (y == Y_W'(V_NEXT)) ? '0 : y + 1'b1;
        return ny[CELL_SH +: ROW_W];
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read bus between the scanout (master) and the framebuffer (slave).
interface vga_scanout_if;
    import vga_scanout_pkg::*;

    logic              fb_req;
    logic [ROW_W-1:0]  fb_addr;
    logic              fb_ack;
    logic [DATA_W-1:0] fb_data;

    modport master (output fb_req, fb_addr, input fb_ack, fb_data);
    modport slave  (input fb_req, fb_addr, output fb_ack, fb_data);

endinterface

// File: rtl/vga_row_fetch.sv
// Per-line framebuffer row fetch: IDLE/REQ/DONE FSM with pending and active
// line buffers; the active buffer is swapped in at the last column of a line.
module vga_row_fetch
    import vga_scanout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    vga_scanout_if.master     fb,
    output logic [DATA_W-1:0] active_row,
    output logic              underrun
);

    fetch_state_e      state;
    logic [DATA_W-1:0] pending_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_IDLE;
            fb.fb_req   <= 1'b0;
            fb.fb_addr  <= '0;
            pending_row <= '0;
            active_row  <= '0;
            underrun    <= 1'b0;
        end else if (x == X_W'(H_NEXT)) begin
            // End of line: commit the fetched row, or flag a missed deadline.
            // An ack arriving exactly now is still on time.
            state     <= FETCH_IDLE;
            fb.fb_req <= 1'b0;
            case (state)
                FETCH_DONE: active_row <= pending_row;
                FETCH_REQ: begin
                    if (fb.fb_ack) active_row <= fb.fb_data;
                    else           underrun   <= 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (x == X_W'(H_FPORCH)) begin
                        state      <= FETCH_REQ;
                        fb.fb_req  <= 1'b1;
                        fb.fb_addr <= next_row(y);
                    end
                end
                FETCH_REQ: begin
                    if (fb.fb_ack) begin
                        pending_row <= fb.fb_data;
                        state       <= FETCH_DONE;
                        fb.fb_req   <= 1'b0;
                    end
                end
                FETCH_DONE: ;
                default: state <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: colours each pixel from a 32x16 one-bit framebuffer and delays
// sync by one cycle. Optional grid overlay: define VGA_SCANOUT_GRID_EN.
module vga_scanout
    import vga_scanout_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               blank_in,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
`ifdef VGA_SCANOUT_GRID_EN
    input  logic [COLOR_W-1:0] grid_color,
`endif
    vga_scanout_if.master      fb,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               underrun
);

    logic [DATA_W-1:0]  active_row;
    logic               in_active;
    logic               pix_set;
    logic [COLOR_W-1:0] rgb_next;
    logic [COLOR_W-1:0] rgb_p1;
    logic               hsync_p1;
    logic               vsync_p1;

    vga_row_fetch u_fetch (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .fb         (fb),
        .active_row (active_row),
        .underrun   (underrun)
    );

    assign in_active = (x < X_W'(H_ACTIVE)) && (y < Y_W'(V_ACTIVE));
    assign pix_set   = active_row[x[CELL_SH +: COL_W]];

    always_comb begin
        rgb_next = bg_color;
        if (blank_in) begin
            rgb_next = '0;
        end else if (in_active) begin
            rgb_next = pix_set ? fg_color : bg_color;
`ifdef VGA_SCANOUT_GRID_EN
            if ((x[CELL_SH-1:0] == '0) || (y[CELL_SH-1:0] == '0))
                rgb_next = grid_color;
`endif
        end
    end

    // Stage p1: registered colour with sync delayed to match
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p1   <= '0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            rgb_p1   <= rgb_next;
            hsync_p1 <= hsync_in;
            vsync_p1 <= vsync_in;
        end
    end

    assign rgb   = rgb_p1;
    assign hsync = hsync_p1;
    assign vsync = vsync_p1;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 clk  input  1  pixel clock (64 MHz); all logic on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 x  input  11  current column from the timing generator (0..1439).
REQ-004 y  input  10  current line from the timing generator (0..740).
REQ-005 hsync_in, vsync_in, blank_in  input  1 each  sync and blank from the timing generator, same cycle as x/y.
REQ-006 fg_color, bg_color  input  6 each  {R[1:0],G[1:0],B[1:0]} for set and clear framebuffer bits.
REQ-007 fb_req  output  1  framebuffer read request.
REQ-008 fb_addr  output  4  framebuffer row index.
REQ-009 fb_ack  input  1  read complete; fb_data valid in the same cycle.
REQ-010 fb_data  input  32  one framebuffer row; bit n is column n.
REQ-011 rgb  output  6  pixel colour, registered.
REQ-012 hsync, vsync  output  1 each  sync delayed to align with rgb.
REQ-013 underrun  output  1  sticky flag: a row fetch missed its deadline.

Function
REQ-014 Framebuffer geometry: 32 columns x 16 rows; each cell is 32x32 screen pixels; col = x[9:5], row = y[8:5].
REQ-015 Output latency: rgb, hsync and vsync are exactly 1 cycle behind x/y/hsync_in/vsync_in.
REQ-016 rgb = 0 when blank_in; else bg_color when x>=1024 or y>=512 (1-pixel edge strip); else fg_color if the active line buffer bit[col]=1, otherwise bg_color.
REQ-017 Fetch FSM states: IDLE, REQ, DONE.
REQ-018 IDLE->REQ when x==1025; fb_addr = row of the next line, where next line = 0 if y==740, else y+1.
REQ-019 In REQ, fb_req=1 and fb_addr is held stable until fb_ack.
REQ-020 On fb_ack in REQ: fb_data loads into the pending buffer; state -> DONE; fb_req drops in the next cycle.
REQ-021 fb_ack outside REQ is ignored.
REQ-022 When x==1439: pending buffer copies to the active buffer if the state is DONE; the state returns to IDLE in all cases.
REQ-023 If the state is REQ when x==1439: fb_req drops; the active buffer keeps its old contents; underrun is set.
REQ-024 underrun clears only on reset.
REQ-025 fb_ack in the same cycle as x==1439 counts as on time: the data is copied directly to the active buffer and underrun is not set.

Reset
REQ-026 On rst: rgb=0, hsync=0, vsync=0, fb_req=0, fb_addr=0, underrun=0, both buffers=0, FSM=IDLE.
REQ-027 A reset asserted mid-fetch drops fb_req on the next edge; after reset, the first fetch starts at the next x==1025.

Configuration
REQ-028 With VGA_SCANOUT_GRID_EN defined: an extra 6-bit input grid_color is present.
REQ-029 With VGA_SCANOUT_GRID_EN defined: visible pixels with x[4:0]==0 or y[4:0]==0 (x<1024, y<512) show grid_color, overriding REQ-016.
REQ-030 Without VGA_SCANOUT_GRID_EN: grid_color does not exist and REQ-016 applies unchanged.

Structure
REQ-031 The shared package holds: cell size (32), grid dimensions (32x16), H_FPORCH (1025), H_NEXT (1439), V_NEXT (740), active limits (1024/512), and the FSM state encoding.
REQ-032 The fetch FSM and both line buffers sit in one sub-module, vga_row_fetch; colour selection and sync delay stay in the top level.

Verification
REQ-033 Scenario 1: rst held 2 cycles, then released -> all outputs 0; first fb_req rises the cycle after x==1025.
REQ-034 Scenario 2: y=31, x=1025, fb_ack returns fb_data=0x00000001 after 3 cycles -> fb_addr=1; on line 32, rgb=fg_color for x 0..31 and bg_color for x 32..1023, each 1 cycle after x.
REQ-035 Scenario 3: fb_ack withheld through x==1439 -> fb_req falls; underrun=1 and stays 1; the next line shows the previous row data.
REQ-036 Scenario 4: y=740, x=1025 -> fb_addr=0; the fetched row is displayed on line 0.
REQ-037 Scenario 5: x=1024, y=100 -> rgb=bg_color; x=1100 (blank) -> rgb=0; hsync output equals hsync_in delayed by 1 cycle.
REQ-038 Scenario 6 (VGA_SCANOUT_GRID_EN defined): x=64 or y=96 in the active area -> rgb=grid_color; x=65, y=97 -> REQ-016 colour.
